// File: rtl/mod24_hour_pkg.sv
// ============================================================================
//  Module      : mod24_hour_pkg
//  Description : Shared constants, set-FSM state encoding and the 24h->12h
//                display mapping used by the clock counter stages.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mod24_hour_pkg;

    // BCD limits for the hour stage
    localparam logic [3:0] BCD_MAX_UNIT       = 4'd9;
    localparam logic [3:0] HR_MAX_TENS        = 4'd2;
    localparam logic [3:0] HR_MAX_UNIT_AT_TOP = 4'd3;

    // Set-button FSM states
    typedef enum logic [1:0] {
        SET_IDLE   = 2'd0,
        SET_HOLD   = 2'd1,
        SET_REPEAT = 2'd2
    } set_state_e;

    // Map an internal 00..23 BCD hour to {pm, tens, units} in 12-hour form
    function automatic logic [8:0] hr_to_12h(input logic [3:0] tens, input logic [3:0] units);
        logic       pm_f;
        logic [3:0] t12;
        logic [3:0] u12;
        pm_f = (tens == 4'd2) || ((tens == 4'd1) && (units >= 4'd2));
        t12  = 4'd0;
        u12  = units;
        case (tens)
            4'd0: begin
                if (units == 4'd0) begin
                    t12 = 4'd1;
                    u12 = 4'd2;
                end
            end
            4'd1: begin
                if (units <= 4'd2) begin
                    t12 = 4'd1;
                end else begin
                    u12 = units - 4'd2;
                end
            end
            4'd2: begin
                // 20,21 -> 08,09 ; 22,23 -> 10,11
                if (units <= 4'd1) begin
                    u12 = units + 4'd8;
                end else begin
                    t12 = 4'd1;
                    u12 = units - 4'd2;
                end
            end
            default: begin
                t12 = 4'd0;
                u12 = 4'd0;
            end
        endcase
        return {pm_f, t12, u12};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod24_hour_sync_edge.sv
// ============================================================================
//  Module      : mod24_hour_sync_edge
//  Description : Two-flop synchroniser with a history flop producing a
//                one-clock rising-edge pulse. Reset value is configurable so
//                a level already high at reset release produces no edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod24_hour_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchroniser chain plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/mod24_hour.sv
// ============================================================================
//  Module      : mod24_hour
//  Description : BCD hour counter 00..23 advanced by the minute-stage carry,
//                with day-rollover pulse and a hold-to-auto-repeat set button.
//                Optional macro HOUR_12H_EN adds a registered 12-hour display
//                mapping and drives the pm flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod24_hour
    import mod24_hour_pkg::*;
#(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 12_500_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       carry_in,
    input  logic       set_btn,
    output logic [3:0] hr_1,
    output logic [3:0] hr_2,
    output logic       day_oc,
    output logic       set_active,
    output logic       pm
);

    localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CYC - 1);

    logic             w_inc_c;
    logic             w_carry_level_unused;   // carry path needs only the edge
    logic             w_set_rise;
    logic             w_set_lvl;
    logic             w_inc_s;
    logic             w_inc;
    logic             w_at_top;

    set_state_e       r_state;
    set_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;

    logic [3:0]       r_hr_1;
    logic [3:0]       r_hr_2;
    logic [3:0]       w_hr_1_nxt;
    logic [3:0]       w_hr_2_nxt;
    logic             r_day_oc;

    mod24_hour_sync_edge #(.RST_VAL(1'b1)) u_sync_carry (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (carry_in),
        .level (w_carry_level_unused),
        .rise  (w_inc_c)
    );

    mod24_hour_sync_edge #(.RST_VAL(1'b1)) u_sync_set (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (set_btn),
        .level (w_set_lvl),
        .rise  (w_set_rise)
    );

    // Set FSM state and hold/repeat timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SET_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Set FSM next state: immediate step on press, then hold delay, then repeat
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_inc_s     = 1'b0;
        case (r_state)
            SET_IDLE: begin
                if (w_set_rise) begin
                    w_inc_s     = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = SET_HOLD;
                end
            end
            SET_HOLD: begin
                if (!w_set_lvl) begin
                    w_state_nxt = SET_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_hold_last) begin
                    w_inc_s     = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = SET_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            SET_REPEAT: begin
                if (!w_set_lvl) begin
                    w_state_nxt = SET_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_repeat_last) begin
                    w_inc_s     = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = SET_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // A coincident carry and set step merge into a single increment
    assign w_inc    = w_inc_c | w_inc_s;
    assign w_at_top = (r_hr_2 == HR_MAX_TENS) && (r_hr_1 == HR_MAX_UNIT_AT_TOP);

    // BCD hour next value with 23 -> 00 wrap
    always_comb begin
        w_hr_1_nxt = r_hr_1;
        w_hr_2_nxt = r_hr_2;
        if (w_inc) begin
            if (w_at_top) begin
                w_hr_1_nxt = 4'd0;
                w_hr_2_nxt = 4'd0;
            end else if (r_hr_1 == BCD_MAX_UNIT) begin
                w_hr_1_nxt = 4'd0;
                w_hr_2_nxt = r_hr_2 + 4'd1;
            end else begin
                w_hr_1_nxt = r_hr_1 + 4'd1;
            end
        end
    end

    // Hour registers and carry-caused day rollover pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hr_1   <= 4'd0;
            r_hr_2   <= 4'd0;
            r_day_oc <= 1'b0;
        end else begin
            r_hr_1   <= w_hr_1_nxt;
            r_hr_2   <= w_hr_2_nxt;
            r_day_oc <= w_inc_c & w_at_top;
        end
    end

    assign day_oc     = r_day_oc;
    assign set_active = (r_state != SET_IDLE);

`ifdef HOUR_12H_EN
    logic [3:0] r_disp_1;
    logic [3:0] r_disp_2;
    logic       r_pm;

    // Registered 12-hour display mapping of the internal 24-hour count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pm     <= 1'b0;
            r_disp_2 <= 4'd0;
            r_disp_1 <= 4'd0;
        end else begin
            {r_pm, r_disp_2, r_disp_1} <= hr_to_12h(r_hr_2, r_hr_1);
        end
    end

    assign hr_1 = r_disp_1;
    assign hr_2 = r_disp_2;
    assign pm   = r_pm;
`else
    assign hr_1 = r_hr_1;
    assign hr_2 = r_hr_2;
    assign pm   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod24_hour.sv
// ============================================================================
//  Module      : tb_mod24_hour
//  Description : Directed self-checking bench for mod24_hour (HOLD_CYC=8,
//                REPEAT_CYC=4). Expected display values follow HOUR_12H_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod24_hour;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       carry_in;
    logic       set_btn;
    logic [3:0] hr_1;
    logic [3:0] hr_2;
    logic       day_oc;
    logic       set_active;
    logic       pm;
    logic [8:0] obs;

    int total = 0;
    int bad   = 0;
    int hr_m  = 0;

    always #5 clk = ~clk;

    assign obs = {pm, hr_2, hr_1};

    mod24_hour #(
        .HOLD_CYC   (8),
        .REPEAT_CYC (4),
        .CNT_W      (26)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .carry_in   (carry_in),
        .set_btn    (set_btn),
        .hr_1       (hr_1),
        .hr_2       (hr_2),
        .day_oc     (day_oc),
        .set_active (set_active),
        .pm         (pm)
    );

    // Expected {pm, tens, units} shown for a binary 24-hour value
    function automatic logic [8:0] exp_disp(input int h);
`ifdef HOUR_12H_EN
        int m;
        m = h % 12;
        if (m == 0) m = 12;
        return {(h >= 12) ? 1'b1 : 1'b0, 4'(m / 10), 4'(m % 10)};
`else
        return {1'b0, 4'(h / 10), 4'(h % 10)};
`endif
    endfunction

    // n carry_in rise/fall pairs; returns number of cycles day_oc was seen high
    task automatic carry_pairs(input int n, output int oc_cnt);
        oc_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) carry_in = 1'b1;
            repeat (4) begin
                @(posedge clk); #1;
                if (day_oc) oc_cnt++;
            end
            @(negedge clk) carry_in = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (day_oc) oc_cnt++;
            end
            hr_m = (hr_m + 1) % 24;
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        carry_in = 1'($urandom);
        set_btn  = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        total++; if (obs !== 9'h000) begin bad++; $display("FAIL reset_hr: got %h want %h", obs, 9'h000); end
        total++; if (day_oc !== 1'b0) begin bad++; $display("FAIL reset_day_oc: got %b want 0", day_oc); end
        total++; if (set_active !== 1'b0) begin bad++; $display("FAIL reset_set_active: got %b want 0", set_active); end
        @(negedge clk);
        carry_in = 1'b1;
        set_btn  = 1'b0;
        rst_n    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++; if (obs !== exp_disp(0)) begin bad++; $display("FAIL release_high_carry: got %h want %h", obs, exp_disp(0)); end
        @(negedge clk) carry_in = 1'b0;
        repeat (5) @(posedge clk);
        hr_m = 0;
    endtask

    task automatic test_carry_wrap;
        int oc;
        carry_pairs(23, oc);
        #1;
        total++; if (oc !== 0) begin bad++; $display("FAIL wrap_no_early_oc: got %0d want 0", oc); end
        total++; if (obs !== exp_disp(23)) begin bad++; $display("FAIL count_to_23: got %h want %h", obs, exp_disp(23)); end
        @(negedge clk) carry_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (obs !== exp_disp(23)) begin bad++; $display("FAIL wrap_before_edge3: got %h want %h", obs, exp_disp(23)); end
        total++; if (day_oc !== 1'b0) begin bad++; $display("FAIL wrap_oc_early: got %b want 0", day_oc); end
        @(posedge clk); #1;
        total++; if (day_oc !== 1'b1) begin bad++; $display("FAIL wrap_oc_pulse: got %b want 1", day_oc); end
        @(posedge clk); #1;
        total++; if (day_oc !== 1'b0) begin bad++; $display("FAIL wrap_oc_width: got %b want 0", day_oc); end
        total++; if (obs !== exp_disp(0)) begin bad++; $display("FAIL wrap_to_00: got %h want %h", obs, exp_disp(0)); end
        @(negedge clk) carry_in = 1'b0;
        repeat (4) @(posedge clk);
        hr_m = 0;
    endtask

    task automatic test_held_carry;
        logic [8:0] prev;
        int         changes;
        changes = 0;
        prev    = obs;
        @(negedge clk) carry_in = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            if (obs !== prev) begin changes++; prev = obs; end
        end
        total++; if (changes !== 1) begin bad++; $display("FAIL held_carry_steps: got %0d want 1", changes); end
        total++; if (obs !== exp_disp(1)) begin bad++; $display("FAIL held_carry_hr: got %h want %h", obs, exp_disp(1)); end
        @(negedge clk) carry_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (obs !== exp_disp(1)) begin bad++; $display("FAIL carry_fall_no_step: got %h want %h", obs, exp_disp(1)); end
        hr_m = 1;
    endtask

    // Button held across one press, one hold expiry and two repeats
    task automatic test_set_repeat(input string tag);
        logic [8:0] prev;
        int         ks[$];
        int         oc;
        logic [23:0] offs;
        oc   = 0;
        prev = obs;
        @(negedge clk) set_btn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (obs !== prev) begin ks.push_back(k); prev = obs; end
            if (day_oc) oc++;
            if (k == 2) begin
                total++; if (set_active !== 1'b0) begin bad++; $display("FAIL %s set_active_pre: got %b want 0", tag, set_active); end
            end
            if (k == 3 || k == 21) begin
                total++; if (set_active !== 1'b1) begin bad++; $display("FAIL %s set_active_k%0d: got %b want 1", tag, k, set_active); end
            end
            if (k == 22) begin
                total++; if (set_active !== 1'b0) begin bad++; $display("FAIL %s set_active_release: got %b want 0", tag, set_active); end
            end
            if (k == 19) begin
                @(negedge clk) set_btn = 1'b0;
            end
        end
        total++; if (ks.size() !== 4) begin bad++; $display("FAIL %s set_step_count: got %0d want 4", tag, ks.size()); end
        if (ks.size() >= 4) begin
            offs = {8'(ks[1] - ks[0]), 8'(ks[2] - ks[0]), 8'(ks[3] - ks[0])};
            total++; if (offs !== 24'h080C10) begin bad++; $display("FAIL %s set_step_offsets: got %h want %h", tag, offs, 24'h080C10); end
        end
        hr_m = (hr_m + 4) % 24;
        total++; if (obs !== exp_disp(hr_m)) begin bad++; $display("FAIL %s set_final_hr: got %h want %h", tag, obs, exp_disp(hr_m)); end
        total++; if (oc !== 0) begin bad++; $display("FAIL %s set_no_day_oc: got %0d want 0", tag, oc); end
    endtask

    task automatic test_set_wrap;
        int oc;
        carry_pairs(17, oc);
        #1;
        total++; if (obs !== exp_disp(22)) begin bad++; $display("FAIL preset_22: got %h want %h", obs, exp_disp(22)); end
        test_set_repeat("wrap");
    endtask

    // Repeat expiry lands on the same cycle as a carry edge at 23, then reset mid-repeat
    task automatic test_coincide_and_reset;
        int         oc;
        int         changes;
        int         act;
        logic [8:0] prev;
        carry_pairs(19, oc);
        #1;
        total++; if (obs !== exp_disp(21)) begin bad++; $display("FAIL preset_21: got %h want %h", obs, exp_disp(21)); end
        @(negedge clk) set_btn = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 14) begin
                total++; if (obs !== exp_disp(23)) begin bad++; $display("FAIL coincide_at_23: got %h want %h", obs, exp_disp(23)); end
            end
            if (k == 15) begin
                total++; if (day_oc !== 1'b1) begin bad++; $display("FAIL coincide_day_oc: got %b want 1", day_oc); end
            end
            if (k == 16) begin
                total++; if (obs !== exp_disp(0)) begin bad++; $display("FAIL coincide_single_step: got %h want %h", obs, exp_disp(0)); end
            end
            if (k == 12) begin
                @(negedge clk) carry_in = 1'b1;
            end
        end
        @(negedge clk) rst_n = 1'b0;
        #2;
        total++; if ({obs, set_active} !== 10'h000) begin bad++; $display("FAIL midrepeat_reset: got %h want %h", {obs, set_active}, 10'h000); end
        @(negedge clk) rst_n = 1'b1;
        changes = 0;
        act     = 0;
        repeat (2) @(posedge clk);
        #1;
        prev = obs;
        repeat (30) begin
            @(posedge clk); #1;
            if (obs !== prev) begin changes++; prev = obs; end
            if (set_active) act++;
        end
        total++; if (changes !== 0) begin bad++; $display("FAIL after_reset_steps: got %0d want 0", changes); end
        total++; if (act !== 0) begin bad++; $display("FAIL after_reset_active: got %0d want 0", act); end
        total++; if (obs !== exp_disp(0)) begin bad++; $display("FAIL after_reset_hr: got %h want %h", obs, exp_disp(0)); end
        @(negedge clk);
        set_btn  = 1'b0;
        carry_in = 1'b0;
        repeat (5) @(posedge clk);
        hr_m = 0;
    endtask

    // Display values at the 12-hour mapping corners, hand-written per build
    task automatic test_display_map;
        int oc;
`ifdef HOUR_12H_EN
        logic [8:0] want12 = 9'h112;
        logic [8:0] want13 = 9'h101;
        logic [8:0] want23 = 9'h111;
        logic [8:0] want00 = 9'h012;
`else
        logic [8:0] want12 = 9'h012;
        logic [8:0] want13 = 9'h013;
        logic [8:0] want23 = 9'h023;
        logic [8:0] want00 = 9'h000;
`endif
        carry_pairs(12, oc);
        #1;
        total++; if (obs !== want12) begin bad++; $display("FAIL map_12: got %h want %h", obs, want12); end
        carry_pairs(1, oc);
        #1;
        total++; if (obs !== want13) begin bad++; $display("FAIL map_13: got %h want %h", obs, want13); end
        carry_pairs(10, oc);
        #1;
        total++; if (obs !== want23) begin bad++; $display("FAIL map_23: got %h want %h", obs, want23); end
        carry_pairs(1, oc);
        #1;
        total++; if (obs !== want00) begin bad++; $display("FAIL map_00: got %h want %h", obs, want00); end
        total++; if (oc !== 1) begin bad++; $display("FAIL map_wrap_oc: got %0d want 1", oc); end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_held_carry();
        test_set_repeat("basic");
        test_set_wrap();
        test_coincide_and_reset();
        test_display_map();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
